// File: rtl/alu_sched.sv
// alu_sched: two-port round-robin scheduler in front of a shared registered ALU.
// Latency: command accepted in cycle t -> ALU inputs in t+1 -> result in FIFO end of t+2 -> response t+3.
// Backpressure: credit of 4 ops in flight (S1 + S2 + FIFO); READY drops when the credit is spent.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqX_valid/ready/last         command handshake per port; last=0 locks the grant
//   reqX_fun, reqX_a, reqX_b      function code and operands per port
//   alu_a, alu_b, alu_fun         registered ALU drive (idle = fun 15, operands 0)
//   alu_res                       registered ALU result, one clock after its inputs
//   rsp_valid/ready               response FIFO head handshake
//   rsp_id, rsp_err, rsp_fun, rsp_data   response fields of the FIFO head (zero when empty)

// Small 4-deep FIFO used for the response queue.
// Latency: head visible the cycle after a push into an empty queue.
// Backpressure: push is dropped when full (the scheduler's credit never lets that happen).
module alu_sched_fifo #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             not_empty,
  output logic [2:0]       count
);

  logic [width-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign not_empty = (count != 3'd0);
  assign do_pop    = pop & not_empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push   = push & ((count != 3'd4) | do_pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module alu_sched #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_last,
  input  logic [3:0]   req0_fun,
  input  logic [n:0]   req0_a,
  input  logic [n:0]   req0_b,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_last,
  input  logic [3:0]   req1_fun,
  input  logic [n:0]   req1_a,
  input  logic [n:0]   req1_b,

  output logic [n:0]   alu_a,
  output logic [n:0]   alu_b,
  output logic [3:0]   alu_fun,
  input  logic [n+1:0] alu_res,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [3:0]   rsp_fun,
  output logic [n+1:0] rsp_data
);

  localparam logic [3:0] fun_idle = 4'd15;
  localparam logic [3:0] fun_div  = 4'd3;
  localparam logic [3:0] fun_shr  = 4'd13;
  localparam logic [3:0] fun_shl  = 4'd14;

  typedef struct packed {
    logic         id;
    logic         err;
    logic [3:0]   fun;
    logic [n+1:0] data;
  } rsp_t;

  localparam int rsp_w = $bits(rsp_t);

  // Arbitration state
  logic locked;     // grant held by lock_id until a last=1 accept
  logic lock_id;
  logic rr_last;    // port granted most recently; reset to 1 so port 0 wins first
  logic chain_ok;   // previous cycle accepted a good, non-last op: a shift may follow

  // Pipeline metadata (operands live in the alu_* output registers)
  logic       s1_vld, s1_err, s1_id;
  logic [3:0] s1_fun;
  logic       s2_vld, s2_err, s2_id;
  logic [3:0] s2_fun;

  // Response queue
  rsp_t       fifo_in;
  rsp_t       fifo_head;
  logic       fifo_ne;
  logic [2:0] fifo_count;
  logic       pop;

  // Accept path
  logic [2:0] inflight;
  logic [2:0] inflight_after_pop;
  logic       credit_ok;
  logic       win;
  logic       acc;
  logic       c_last;
  logic [3:0] c_fun;
  logic [n:0] c_a;
  logic [n:0] c_b;
  logic       c_shift;
  logic       c_err;

  assign pop = fifo_ne & rsp_ready;

  // Credit counts every op that will still occupy a slot after this cycle's pop.
  assign inflight           = {2'b00, s1_vld} + {2'b00, s2_vld} + fifo_count;
  assign inflight_after_pop = inflight - {2'b00, pop};
  assign credit_ok          = (inflight_after_pop < 3'd4);

  // Port that may be accepted this cycle. With no valid request and no lock
  // this defaults toward port 0 or the round-robin favourite; harmless since
  // nothing is accepted.
  always_comb begin
    win = 1'b0;
    if (locked) begin
      win = lock_id;
    end else if (req0_valid & req1_valid) begin
      win = ~rr_last;
    end else begin
      win = req1_valid;
    end
  end

  assign req0_ready = credit_ok & ~win;
  assign req1_ready = credit_ok &  win;

  always_comb begin
    c_last = req0_last;
    c_fun  = req0_fun;
    c_a    = req0_a;
    c_b    = req0_b;
    acc    = credit_ok & req0_valid;
    if (win) begin
      c_last = req1_last;
      c_fun  = req1_fun;
      c_a    = req1_a;
      c_b    = req1_b;
      acc    = credit_ok & req1_valid;
    end
  end

  // A shift only makes sense on the ALU's own result from the op one cycle
  // ahead of it, so it needs an unbroken good predecessor in the same burst.
  assign c_shift = (c_fun == fun_shr) | (c_fun == fun_shl);
  assign c_err   = (c_shift & ~chain_ok) | ((c_fun == fun_div) & (c_b == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_id  <= 1'b0;
      rr_last  <= 1'b1;
      chain_ok <= 1'b0;
    end else if (acc) begin
      locked   <= ~c_last;
      lock_id  <= win;
      rr_last  <= win;
      chain_ok <= ~c_err & ~c_last;
    end else begin
      chain_ok <= 1'b0;
    end
  end

  // S1: issue register. Errors and empty slots drive the idle code, which
  // also clears the ALU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_id   <= 1'b0;
      s1_fun  <= 4'd0;
      alu_fun <= fun_idle;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      s1_vld <= acc;
      s1_err <= c_err;
      s1_id  <= win;
      s1_fun <= c_fun;
      if (acc & ~c_err) begin
        alu_fun <= c_fun;
        alu_a   <= c_a;
        alu_b   <= c_b;
      end else begin
        alu_fun <= fun_idle;
        alu_a   <= '0;
        alu_b   <= '0;
      end
    end
  end

  // S2: the ALU registers S1's inputs during this stage, so alu_res belongs
  // to the S2 op.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_err <= 1'b0;
      s2_id  <= 1'b0;
      s2_fun <= 4'd0;
    end else begin
      s2_vld <= s1_vld;
      s2_err <= s1_err;
      s2_id  <= s1_id;
      s2_fun <= s1_fun;
    end
  end

  always_comb begin
    fifo_in.id   = s2_id;
    fifo_in.err  = s2_err;
    fifo_in.fun  = s2_fun;
    fifo_in.data = s2_err ? '0 : alu_res;
  end

  alu_sched_fifo #(
    .width (rsp_w)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_vld),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .not_empty (fifo_ne),
    .count     (fifo_count)
  );

  // Response fields read as zero whenever the queue is empty.
  assign rsp_valid = fifo_ne;
  assign rsp_id    = fifo_ne & fifo_head.id;
  assign rsp_err   = fifo_ne & fifo_head.err;
  assign rsp_fun   = fifo_ne ? fifo_head.fun  : 4'd0;
  assign rsp_data  = fifo_ne ? fifo_head.data : '0;

endmodule
